// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I front-end: widths, vectors, PC FSM states
// and small address helpers.
package rv32_pkg;

  localparam int          RV_XLEN         = 32;
  localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] RV_TRAP_VECTOR  = 32'h0000_0100;

  // Program-counter unit control states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // An RV32I instruction address must be word aligned (no compressed ISA).
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_boot_counter.sv
// Boot delay timer: counts down from BOOT_CYCLES-1 while enabled and raises
// done once zero is reached. BOOT_CYCLES of 0 or 1 yields done straight out of
// reset, so the owner leaves BOOT on the first clock edge.
module pc_boot_counter
  import rv32_pkg::*;
#(
  parameter int BOOT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic done
);

  localparam int            CW   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = (BOOT_CYCLES > 1) ? CW'(BOOT_CYCLES - 1) : {CW{1'b0}};

  logic [CW-1:0] remain_r;
  logic          zero_s;

  assign zero_s = (remain_r == {CW{1'b0}});

  // Remaining boot cycles; reloaded by reset so BOOT replays after every reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remain_r <= LOAD;
    end else if (enable && !zero_s) begin
      remain_r <= remain_r - CW'(1'b1);
    end else begin
      remain_r <= remain_r;
    end
  end

  assign done = zero_s;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot delay, valid/ready fetch handshake,
// redirect / trap / halt control and misaligned-target trapping.
module pc_unit
  import rv32_pkg::*;
#(
  parameter int              XLEN         = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RV_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(RV_TRAP_VECTOR),
  parameter int              BOOT_CYCLES  = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic             trap_taken,
  output logic [XLEN-1:0]  bad_addr,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(3'd4);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1'b1);

  pc_state_e        state_r,       state_nxt_s;
  logic [XLEN-1:0]  pc_r,          pc_nxt_s;
  logic [XLEN-1:0]  bad_addr_r,    bad_addr_nxt_s;
  logic [CNT_W-1:0] fetch_count_r, fetch_count_nxt_s;
  logic             trap_taken_r,  trap_taken_nxt_s;
  logic             fetch_valid_r, halted_r;
  logic             boot_done_s;
  logic             fire_s;

  pc_boot_counter #(
    .BOOT_CYCLES (BOOT_CYCLES)
  ) u_boot (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_r == ST_BOOT),
    .done    (boot_done_s)
  );

  // A fetch is accepted only while requesting (RUN) and imem is ready.
  assign fire_s = fetch_valid_r && fetch_ready;

  // Next-state, next-pc and side-effect decode; trap beats redirect beats step.
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    bad_addr_nxt_s    = bad_addr_r;
    trap_taken_nxt_s  = 1'b0;
    fetch_count_nxt_s = fetch_count_r;

    if (fire_s) begin
      fetch_count_nxt_s = fetch_count_r + CNT_STEP;
    end else begin
      fetch_count_nxt_s = fetch_count_r;
    end

    case (state_r)
      ST_BOOT: begin
        if (boot_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_BOOT;
        end
      end

      ST_RUN: begin
        if (trap_req) begin
          pc_nxt_s         = TRAP_VECTOR;
          trap_taken_nxt_s = 1'b1;
        end else if (redirect_valid) begin
          if (is_misaligned(redirect_target[1:0])) begin
            pc_nxt_s         = TRAP_VECTOR;
            trap_taken_nxt_s = 1'b1;
            bad_addr_nxt_s   = redirect_target;
          end else begin
            pc_nxt_s = redirect_target;
          end
        end else if (fire_s) begin
          pc_nxt_s = pc_r + PC_STEP;
        end else begin
          pc_nxt_s = pc_r;
        end

        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_HALT: begin
        if (trap_req) begin
          pc_nxt_s         = TRAP_VECTOR;
          trap_taken_nxt_s = 1'b1;
          state_nxt_s      = ST_RUN;
        end else if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end

      default: begin
        state_nxt_s = ST_BOOT;
        pc_nxt_s    = RESET_VECTOR;
      end
    endcase
  end

  // State, pc and status registers; outputs flop alongside the state they reflect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VECTOR;
      bad_addr_r    <= {XLEN{1'b0}};
      trap_taken_r  <= 1'b0;
      fetch_count_r <= {CNT_W{1'b0}};
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      bad_addr_r    <= bad_addr_nxt_s;
      trap_taken_r  <= trap_taken_nxt_s;
      fetch_count_r <= fetch_count_nxt_s;
      fetch_valid_r <= (state_nxt_s == ST_RUN);
      halted_r      <= (state_nxt_s == ST_HALT);
    end
  end

  assign pc          = pc_r;
  assign pc_plus4    = pc_r + PC_STEP;
  assign fetch_valid = fetch_valid_r;
  assign halted      = halted_r;
  assign trap_taken  = trap_taken_r;
  assign bad_addr    = bad_addr_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: each task applies a table of per-cycle inputs,
// queues the expected post-edge outputs, then pops and compares them.
module tb_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        halt_req;
  logic        resume;
  logic        trap_taken;
  logic [31:0] bad_addr;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        halted;
    logic        trap;
    logic [31:0] bad;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        tr;
    logic        hl;
    logic        rs;
    exp_t        ex;
  } row_t;

  exp_t sb[$];
  exp_t obs;
  exp_t e;
  int   n_checks;
  int   n_fail;

  assign obs = {pc, fetch_valid, halted, trap_taken, bad_addr, fetch_count};

  pc_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume          (resume),
    .trap_taken      (trap_taken),
    .bad_addr        (bad_addr),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] p, input logic fv, input logic h,
                              input logic t, input logic [31:0] b, input logic [31:0] c);
    exp_t x;
    x.pc = p; x.fv = fv; x.halted = h; x.trap = t; x.bad = b; x.cnt = c;
    return x;
  endfunction

  function automatic row_t row(input logic rdy, input logic rv, input logic [31:0] tgt,
                               input logic tr, input logic hl, input logic rs, input exp_t ex);
    row_t r;
    r.rdy = rdy; r.rv = rv; r.tgt = tgt; r.tr = tr; r.hl = hl; r.rs = rs; r.ex = ex;
    return r;
  endfunction

  task automatic drive(input row_t r);
    fetch_ready     = r.rdy;
    redirect_valid  = r.rv;
    redirect_target = r.tgt;
    trap_req        = r.tr;
    halt_req        = r.hl;
    resume          = r.rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t idle;
    idle = row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0));
    reset_n = 1'b0;
    drive(idle);
    #2;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(idle.ex);
      if (i == 1) tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_boot_fetch();
    row_t rows[$];
    for (int i = 0; i < 4; i++)
      rows.push_back(row(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0,
                         mk(32'h0, (i == 3), 1'b0, 1'b0, 32'h0, 32'd0)));
    rows[3].rdy = 1'b0; rows[3].rv = 1'b0; rows[3].tr = 1'b0; rows[3].hl = 1'b0;
    for (int i = 1; i <= 3; i++)
      rows.push_back(row(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                         mk(32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h0, 32'(i))));
    reset_n = 1'b1;
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL boot_fetch[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    for (int i = 0; i < 5; i++)
      rows.push_back(row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                         mk(32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e || pc_plus4 !== 32'h10) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h pc4=%h bundle=%h, want pc=%h pc4=00000010 bundle=%h",
                 i, pc, pc_plus4, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    rows.push_back(row(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, mk(32'h200, 1'b1, 1'b0, 1'b0, 32'h0,   32'd3)));
    rows.push_back(row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, mk(32'h200, 1'b1, 1'b0, 1'b0, 32'h0,   32'd3)));
    rows.push_back(row(1'b0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b1, 32'h202, 32'd3)));
    rows.push_back(row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b0, 32'h202, 32'd3)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_trap_halt();
    row_t rows[$];
    rows.push_back(row(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b1, 32'h202, 32'd3)));
    rows.push_back(row(1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 1'b0, mk(32'h40,  1'b0, 1'b1, 1'b0, 32'h202, 32'd3)));
    rows.push_back(row(1'b1, 1'b1, 32'h81,  1'b0, 1'b0, 1'b0, mk(32'h40,  1'b0, 1'b1, 1'b0, 32'h202, 32'd3)));
    rows.push_back(row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, mk(32'h40,  1'b1, 1'b0, 1'b0, 32'h202, 32'd3)));
    rows.push_back(row(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, mk(32'h44,  1'b0, 1'b1, 1'b0, 32'h202, 32'd4)));
    rows.push_back(row(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, mk(32'h100, 1'b1, 1'b0, 1'b1, 32'h202, 32'd4)));
    rows.push_back(row(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b0, 32'h202, 32'd4)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL trap_halt[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    rows.push_back(row(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, mk(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h202, 32'd4)));
    rows.push_back(row(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, mk(32'h0,         1'b1, 1'b0, 1'b0, 32'h202, 32'd5)));
    rows.push_back(row(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, mk(32'h4,         1'b1, 1'b0, 1'b0, 32'h202, 32'd6)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(row(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, mk(32'h10,  1'b1, 1'b0, 1'b0, 32'h202, 32'd7)));
    rows.push_back(row(1'b1, 1'b1, 32'h21, 1'b0, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b1, 32'h21,  32'd8)));
    rows.push_back(row(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, mk(32'h100, 1'b1, 1'b0, 1'b1, 32'h21,  32'd9)));
    rows.push_back(row(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, mk(32'h104, 1'b1, 1'b0, 1'b0, 32'h21,  32'd10)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    row_t idle;
    idle = row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0));
    drive(idle);
    #3;
    reset_n = 1'b0;
    #1;
    sb.push_back(idle.ex);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h bundle=%h, want pc=%h bundle=%h", pc, obs, e.pc, e);
    end
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      rows.push_back(row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                         mk(32'h0, (i == 3), 1'b0, 1'b0, 32'h0, 32'd0)));
    rows.push_back(row(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1)));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i].ex);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reboot[%0d]: got pc=%h bundle=%h, want pc=%h bundle=%h", i, pc, obs, e.pc, e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect();
    test_trap_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
